// File: rtl/tree_mac_result_collector.sv
// Collects partial sums from the MAC tree into a ROWS x COLS tile, then drains
// the finished tile row-major over a valid/ready stream. The input is never stalled.
module tree_mac_result_collector #(
   parameter int DATA_WIDTH      = 8,
   parameter int ADDRESS_WIDTH_I = 8,
   parameter int ADDRESS_WIDTH_K = 8,
   parameter int ROWS            = 4,
   parameter int COLS            = 4,
   parameter int K_PASSES        = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_WIDTH-1:0]      sum_in,
   input  logic [ADDRESS_WIDTH_I-1:0] addr_i_in,
   input  logic [ADDRESS_WIDTH_K-1:0] addr_k_in,
   input  logic                       val_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic [ADDRESS_WIDTH_I-1:0] out_addr_i,
   output logic [ADDRESS_WIDTH_K-1:0] out_addr_k,
   output logic                       out_last,
   output logic                       busy,
   output logic                       err_drop,
   output logic                       err_addr
);

   localparam int ENTRIES = ROWS * COLS;
   localparam int TOTAL   = ENTRIES * K_PASSES;
   localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int CNT_W   = $clog2(TOTAL + 1);
   localparam logic [ADDRESS_WIDTH_I:0] ROWS_W = (ADDRESS_WIDTH_I + 1)'(ROWS);
   localparam logic [ADDRESS_WIDTH_K:0] COLS_W = (ADDRESS_WIDTH_K + 1)'(COLS);

   typedef enum logic {COLLECT, DRAIN} state_t;

   state_t                state;
   state_t                state_next;
   logic [CNT_W-1:0]      count;
   logic [IDX_W-1:0]      p;
   logic [IDX_W-1:0]      idx;
   logic [ENTRIES-1:0]    touched;
   logic [ENTRIES-1:0]    hit;
   logic [DATA_WIDTH-1:0] acc [ENTRIES];
   logic                  in_range;
   logic                  accept;
   logic                  bad_addr;
   logic                  drop;
   logic                  handshake;
   logic                  last;
   logic                  tile_done;

   assign in_range  = ({1'b0, addr_i_in} < ROWS_W) && ({1'b0, addr_k_in} < COLS_W);
   assign idx       = IDX_W'(int'(addr_i_in) * COLS + int'(addr_k_in));
   assign last      = (p == IDX_W'(ENTRIES - 1));
   assign tile_done = handshake && last;

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      bad_addr   = 1'b0;
      drop       = 1'b0;
      handshake  = 1'b0;
      case (state)
         COLLECT: begin
            if (val_in) begin
               if (in_range) begin
                  accept = 1'b1;
                  // Completion is purely count based; per-entry pass counts are not tracked.
                  if (count == CNT_W'(TOTAL - 1))
                     state_next = DRAIN;
               end else begin
                  bad_addr = 1'b1;
               end
            end
         end
         DRAIN: begin
            drop      = val_in;
            handshake = out_ready;
            if (out_ready && last)
               state_next = COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= COLLECT;
         count    <= '0;
         p        <= '0;
         touched  <= '0;
         err_drop <= 1'b0;
         err_addr <= 1'b0;
      end else begin
         state <= state_next;
         if (tile_done)
            count <= '0;
         else if (accept)
            count <= count + 1'b1;
         if (tile_done)
            p <= '0;
         else if (handshake)
            p <= p + 1'b1;
         if (tile_done)
            touched <= '0;
         else
            touched <= touched | hit;
         if (drop)
            err_drop <= 1'b1;
         if (bad_addr)
            err_addr <= 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_hit
         assign hit[gi] = accept && (idx == IDX_W'(gi));
      end
   endgenerate

   // Accumulators need no reset: the touched bits decide whether they are loaded or summed.
   always_ff @(posedge clk) begin
      for (int j = 0; j < ENTRIES; j++) begin
         if (hit[j])
            acc[j] <= touched[j] ? acc[j] + sum_in : sum_in;
      end
   end

   assign busy       = (state == DRAIN);
   assign out_valid  = busy;
   assign out_last   = busy && last;
   assign out_data   = (busy && touched[p]) ? acc[p] : '0;
   assign out_addr_i = ADDRESS_WIDTH_I'(int'(p) / COLS);
   assign out_addr_k = ADDRESS_WIDTH_K'(int'(p) % COLS);

endmodule

// File: tb/tb_tree_mac_result_collector.sv
// Directed bench for tree_mac_result_collector with a 2x2 tile and two passes
// per element; expected drain values are hand computed.
module tb_tree_mac_result_collector;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] sum_in = '0;
   logic [7:0] addr_i_in = '0;
   logic [7:0] addr_k_in = '0;
   logic       val_in = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic [7:0] out_addr_i;
   logic [7:0] out_addr_k;
   logic       out_last;
   logic       busy;
   logic       err_drop;
   logic       err_addr;

   int vectors = 0;
   int miscompares = 0;

   int ta_i [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
   int ta_k [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
   int ta_s [8] = '{3, 4, 5, 6, 7, 1, 200, 100};

   always #5 clk = ~clk;

   tree_mac_result_collector #(
      .DATA_WIDTH(8), .ADDRESS_WIDTH_I(8), .ADDRESS_WIDTH_K(8),
      .ROWS(2), .COLS(2), .K_PASSES(2)
   ) dut (
      .clk(clk), .reset(reset),
      .sum_in(sum_in), .addr_i_in(addr_i_in), .addr_k_in(addr_k_in), .val_in(val_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr_i(out_addr_i), .out_addr_k(out_addr_k), .out_last(out_last),
      .busy(busy), .err_drop(err_drop), .err_addr(err_addr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   // Called and returns at a falling edge; the arrival is captured on the rising edge between.
   task automatic send(input int i, input int k, input int s);
      addr_i_in = 8'(i);
      addr_k_in = 8'(k);
      sum_in    = 8'(s);
      val_in    = 1'b1;
      $display("send (%0d,%0d) sum=%0d", i, k, s);
      @(negedge clk);
      val_in = 1'b0;
   endtask

   task automatic send_a(input int first, input int final_idx);
      for (int n = first; n <= final_idx; n++)
         send(ta_i[n], ta_k[n], ta_s[n]);
   endtask

   task automatic send_b();
      for (int n = 0; n < 8; n++)
         send(ta_i[n], ta_k[n], n + 1);
   endtask

   task automatic expect_tile(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3, input bit stall, input bit drop_last);
      logic [7:0] exp_v [4];
      int n;
      int cyc;
      exp_v = '{e0, e1, e2, e3};
      n   = 0;
      cyc = 0;
      while (n < 4 && cyc < 64) begin
         out_ready = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
         if (out_valid) begin
            check("data", out_data, exp_v[n]);
            check("addr_i", out_addr_i, n / 2);
            check("addr_k", out_addr_k, n % 2);
            check("last", out_last, (n == 3));
            if (drop_last && n == 3) begin
               addr_i_in = 8'd0;
               addr_k_in = 8'd0;
               sum_in    = 8'd99;
               val_in    = 1'b1;
            end
            if (out_ready) begin
               $display("drain (%0d,%0d) = %0d last=%0d", out_addr_i, out_addr_k, out_data, out_last);
               n++;
            end
         end
         cyc++;
         @(negedge clk);
         val_in = 1'b0;
      end
      check("handshakes", n, 4);
      check("valid_after", out_valid, 0);
      check("busy_after", busy, 0);
      out_ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_last", out_last, 0);
      check("rst_data", out_data, 0);
      check("rst_addr", {out_addr_i, out_addr_k}, 0);
      check("rst_errs", {err_drop, err_addr}, 0);
      reset = 1'b0;
      @(negedge clk);

      // Basic tile, latency and wrap of 200+100.
      send_a(0, 6);
      check("pre_valid", out_valid, 0);
      send_a(7, 7);
      check("latency", out_valid, 1);
      check("busy_drain", busy, 1);
      expect_tile(8'd7, 8'd11, 8'd8, 8'd44, 1'b0, 1'b0);

      // Same tile with ready toggling 1,0,0,1.
      send_a(0, 7);
      expect_tile(8'd7, 8'd11, 8'd8, 8'd44, 1'b1, 1'b0);

      // All arrivals to one element; untouched elements drain as zero.
      for (int n = 0; n < 8; n++)
         send(0, 0, 9);
      expect_tile(8'd72, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      check("err_addr_clean", err_addr, 0);
      check("err_drop_clean", err_drop, 0);

      // Out-of-range row: flagged, not counted.
      send(2, 0, 5);
      check("err_addr_set", err_addr, 1);
      check("err_drop_still", err_drop, 0);
      send_a(0, 6);
      check("no_early_drain", out_valid, 0);
      send_a(7, 7);
      check("drain_after_8", out_valid, 1);
      expect_tile(8'd7, 8'd11, 8'd8, 8'd44, 1'b0, 1'b0);

      // Arrivals during drain (stalled, and on the final handshake) are dropped.
      send_a(0, 7);
      out_ready = 1'b0;
      send(0, 0, 50);
      check("err_drop_set", err_drop, 1);
      expect_tile(8'd7, 8'd11, 8'd8, 8'd44, 1'b0, 1'b1);
      send_b();
      expect_tile(8'd3, 8'd7, 8'd11, 8'd15, 1'b0, 1'b0);

      // Reset after two handshakes abandons the tile.
      send_a(0, 7);
      out_ready = 1'b1;
      check("mid_data0", out_data, 7);
      @(negedge clk);
      check("mid_data1", out_data, 11);
      @(negedge clk);
      check("mid_valid", out_valid, 1);
      reset = 1'b1;
      #1;
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_errs", {err_drop, err_addr}, 0);
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check("post_rst_idle", out_valid, 0);
      send_b();
      expect_tile(8'd3, 8'd7, 8'd11, 8'd15, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
